// File: rtl/pci_target_ready_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pci_tgt_pkg
// Description : Shared types and constants for the PCI target-ready
//               controller: FSM state encoding, active-low signal levels
//               and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pci_tgt_pkg;

  // Target-side transaction state.
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT       = 2'd1,
    S_READY      = 2'd2,
    S_DISCONNECT = 2'd3
  } tgt_state_e;

  // PCI control lines are active low.
  localparam logic c_ASSERT_N   = 1'b0;
  localparam logic c_DEASSERT_N = 1'b1;

  // Bits needed to hold values 0..max_val; never narrower than one bit so
  // a zero-valued parameter still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pci_target_ready_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pci_target_ready_ctrl_if
// Description : Bus bundle between the DEVSEL decoder / initiator side /
//               storage block and the target-ready controller.
//   devsel_n, frame_n, irdy_n, storage_ready : into the controller
//   trdy_n, stop_n, data_xfer, burst_count   : out of the controller
//   master modport : the side that drives the bus inputs
//   slave  modport : the target-ready controller
// Revision    : 1.0 - initial release
// ============================================================================
interface pci_target_ready_ctrl_if #(
  parameter int CNT_W = 4
) ();

  logic             devsel_n;
  logic             frame_n;
  logic             irdy_n;
  logic             storage_ready;
  logic             trdy_n;
  logic             stop_n;
  logic             data_xfer;
  logic [CNT_W-1:0] burst_count;

  modport master (
    output devsel_n,
    output frame_n,
    output irdy_n,
    output storage_ready,
    input  trdy_n,
    input  stop_n,
    input  data_xfer,
    input  burst_count
  );

  modport slave (
    input  devsel_n,
    input  frame_n,
    input  irdy_n,
    input  storage_ready,
    output trdy_n,
    output stop_n,
    output data_xfer,
    output burst_count
  );

endinterface
`default_nettype wire

// File: rtl/pci_target_ready_ctrl_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : pci_wait_counter
// Description : Loadable down-counter with a zero flag, clocked on the
//               falling edge of the PCI clock.
//   i_clk  -> clk, rst : falling-edge clock, synchronous active-high reset
//   i_load / i_load_val : load a new count (load wins over decrement)
//   i_dec               : decrement by one (saturates at zero)
//   o_zero              : count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module pci_wait_counter #(
  parameter int WIDTH = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  input  wire logic             i_dec,
  output logic                  o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(negedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pci_target_ready_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pci_target_ready_ctrl
// Description : PCI target-ready controller. Drives TRDY#/STOP# for a
//               claimed transaction with programmable initial wait states,
//               storage-paced wait insertion, data-phase counting and a
//               target disconnect after MAX_BURST phases.
//   clk  : PCI clock, all registers update on the falling edge
//   rst  : synchronous active-high reset
//   bus  : slave modport (devsel_n, frame_n, irdy_n, storage_ready in;
//          trdy_n, stop_n, data_xfer, burst_count out)
// Revision    : 1.0 - initial release
// ============================================================================
module pci_target_ready_ctrl
  import pci_tgt_pkg::*;
#(
  parameter int INITIAL_WAIT = 0,
  parameter int MAX_BURST    = 8,
  parameter int CNT_W        = cnt_width(MAX_BURST)
) (
  input  wire logic                clk,
  input  wire logic                rst,
  pci_target_ready_ctrl_if.slave   bus
);

  localparam int WAIT_W       = cnt_width(INITIAL_WAIT);
  localparam int c_WAIT_LOAD  = (INITIAL_WAIT > 0) ? INITIAL_WAIT - 1 : 0;
  localparam bit c_NO_WAIT    = (INITIAL_WAIT == 0);

  tgt_state_e       r_state;
  tgt_state_e       w_state_nxt;
  logic             r_trdy_n;
  logic             w_trdy_nxt;
  logic             r_stop_n;
  logic             w_stop_nxt;
  logic             r_data_xfer;
  logic [CNT_W-1:0] r_burst_count;

  logic             w_xfer;
  logic             w_count_en;
  logic             w_count_clr;
  logic             w_last_allowed;
  logic             w_wait_load;
  logic             w_wait_dec;
  logic             w_wait_zero;

  // A data phase completes when both sides are ready at the sampling edge.
  assign w_xfer         = (r_trdy_n == c_ASSERT_N) && (bus.irdy_n == c_ASSERT_N);
  // This transfer is the last one the target will take in this burst.
  assign w_last_allowed = (r_burst_count == CNT_W'(MAX_BURST - 1));

  pci_wait_counter #(
    .WIDTH (WAIT_W)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_wait_load),
    .i_load_val (WAIT_W'(c_WAIT_LOAD)),
    .i_dec      (w_wait_dec),
    .o_zero     (w_wait_zero)
  );

  always_ff @(negedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_trdy_n      <= c_DEASSERT_N;
      r_stop_n      <= c_DEASSERT_N;
      r_data_xfer   <= 1'b0;
      r_burst_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_trdy_n    <= w_trdy_nxt;
      r_stop_n    <= w_stop_nxt;
      r_data_xfer <= w_count_en;
      if (w_count_clr) begin
        r_burst_count <= '0;
      end else if (w_count_en) begin
        r_burst_count <= r_burst_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_trdy_nxt  = r_trdy_n;
    w_stop_nxt  = r_stop_n;
    w_count_en  = 1'b0;
    w_count_clr = 1'b0;
    w_wait_load = 1'b0;
    w_wait_dec  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_trdy_nxt = c_DEASSERT_N;
        w_stop_nxt = c_DEASSERT_N;
        if (bus.devsel_n == c_ASSERT_N) begin
          w_count_clr = 1'b1;
          if (c_NO_WAIT) begin
            w_state_nxt = S_READY;
            w_trdy_nxt  = ~bus.storage_ready;
          end else begin
            w_state_nxt = S_WAIT;
            w_wait_load = 1'b1;
          end
        end
      end

      S_WAIT: begin
        w_trdy_nxt = c_DEASSERT_N;
        w_stop_nxt = c_DEASSERT_N;
        if (bus.devsel_n == c_DEASSERT_N) begin
          w_state_nxt = S_IDLE;
        end else if (!w_wait_zero) begin
          w_wait_dec = 1'b1;
        end else begin
          w_state_nxt = S_READY;
          w_trdy_nxt  = ~bus.storage_ready;
        end
      end

      S_READY: begin
        w_stop_nxt = c_DEASSERT_N;
        if (bus.devsel_n == c_DEASSERT_N) begin
          // Claim lost: abandon the phase without counting it.
          w_state_nxt = S_IDLE;
          w_trdy_nxt  = c_DEASSERT_N;
        end else if (w_xfer) begin
          w_count_en = 1'b1;
          if (bus.frame_n == c_DEASSERT_N) begin
            w_state_nxt = S_IDLE;
            w_trdy_nxt  = c_DEASSERT_N;
          end else if (w_last_allowed) begin
            w_state_nxt = S_DISCONNECT;
            w_trdy_nxt  = c_DEASSERT_N;
            w_stop_nxt  = c_ASSERT_N;
          end else begin
            w_trdy_nxt = ~bus.storage_ready;
          end
        end else if (r_trdy_n == c_ASSERT_N) begin
          // TRDY# may not be withdrawn until the phase completes.
          w_trdy_nxt = c_ASSERT_N;
        end else begin
          w_trdy_nxt = ~bus.storage_ready;
        end
      end

      S_DISCONNECT: begin
        w_trdy_nxt = c_DEASSERT_N;
        w_stop_nxt = c_ASSERT_N;
        if ((bus.frame_n == c_DEASSERT_N) || (bus.devsel_n == c_DEASSERT_N)) begin
          w_state_nxt = S_IDLE;
          w_stop_nxt  = c_DEASSERT_N;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_trdy_nxt  = c_DEASSERT_N;
        w_stop_nxt  = c_DEASSERT_N;
      end
    endcase
  end

  assign bus.trdy_n      = r_trdy_n;
  assign bus.stop_n      = r_stop_n;
  assign bus.data_xfer   = r_data_xfer;
  assign bus.burst_count = r_burst_count;

endmodule
`default_nettype wire

// File: tb/tb_pci_target_ready_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pci_target_ready_ctrl
// Description : Directed self-checking bench for pci_target_ready_ctrl.
//               Three instances: A (no wait, burst 8), B (2 wait states,
//               burst 8), C (no wait, burst 1). Inputs change 1 time unit
//               after each falling edge; outputs are checked at that point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pci_target_ready_ctrl;
  import pci_tgt_pkg::*;

  localparam int CW8 = cnt_width(8);
  localparam int CW1 = cnt_width(1);

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pci_target_ready_ctrl_if #(.CNT_W(CW8)) if_a ();
  pci_target_ready_ctrl_if #(.CNT_W(CW8)) if_b ();
  pci_target_ready_ctrl_if #(.CNT_W(CW1)) if_c ();

  pci_target_ready_ctrl #(.INITIAL_WAIT(0), .MAX_BURST(8), .CNT_W(CW8)) u_dut_a (
    .clk (clk), .rst (rst), .bus (if_a.slave));
  pci_target_ready_ctrl #(.INITIAL_WAIT(2), .MAX_BURST(8), .CNT_W(CW8)) u_dut_b (
    .clk (clk), .rst (rst), .bus (if_b.slave));
  pci_target_ready_ctrl #(.INITIAL_WAIT(0), .MAX_BURST(1), .CNT_W(CW1)) u_dut_c (
    .clk (clk), .rst (rst), .bus (if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic chk_a(input string tag, input logic t, input logic s, input logic d, input int c);
    check({tag, ".trdy_n"}, 32'(if_a.trdy_n), 32'(t));
    check({tag, ".stop_n"}, 32'(if_a.stop_n), 32'(s));
    check({tag, ".data_xfer"}, 32'(if_a.data_xfer), 32'(d));
    check({tag, ".burst_count"}, 32'(if_a.burst_count), 32'(c));
  endtask

  task automatic chk_b(input string tag, input logic t, input logic s, input logic d, input int c);
    check({tag, ".trdy_n"}, 32'(if_b.trdy_n), 32'(t));
    check({tag, ".stop_n"}, 32'(if_b.stop_n), 32'(s));
    check({tag, ".data_xfer"}, 32'(if_b.data_xfer), 32'(d));
    check({tag, ".burst_count"}, 32'(if_b.burst_count), 32'(c));
  endtask

  task automatic chk_c(input string tag, input logic t, input logic s, input logic d, input int c);
    check({tag, ".trdy_n"}, 32'(if_c.trdy_n), 32'(t));
    check({tag, ".stop_n"}, 32'(if_c.stop_n), 32'(s));
    check({tag, ".data_xfer"}, 32'(if_c.data_xfer), 32'(d));
    check({tag, ".burst_count"}, 32'(if_c.burst_count), 32'(c));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    if_a.devsel_n = 1; if_a.frame_n = 1; if_a.irdy_n = 1; if_a.storage_ready = 0;
    if_b.devsel_n = 1; if_b.frame_n = 1; if_b.irdy_n = 1; if_b.storage_ready = 0;
    if_c.devsel_n = 1; if_c.frame_n = 1; if_c.irdy_n = 1; if_c.storage_ready = 0;

    // Reset state.
    step(); step();
    chk_a("rst_a", 1, 1, 0, 0);
    chk_b("rst_b", 1, 1, 0, 0);
    chk_c("rst_c", 1, 1, 0, 0);
    rst = 1'b0;
    step();
    chk_a("idle_a", 1, 1, 0, 0);

    // 1: zero-wait burst of 8 ending in a target disconnect.
    if_a.devsel_n = 0; if_a.frame_n = 0; if_a.irdy_n = 0; if_a.storage_ready = 1;
    step(); chk_a("t1_e0", 0, 1, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      step(); chk_a($sformatf("t1_e%0d", k), 0, 1, 1, k);
    end
    step(); chk_a("t1_e8", 1, 0, 1, 8);
    step(); chk_a("t1_disc_hold", 1, 0, 0, 8);
    if_a.frame_n = 1; if_a.irdy_n = 1;
    step(); chk_a("t1_stop_rel", 1, 1, 0, 8);
    if_a.devsel_n = 1;
    step(); chk_a("t1_idle", 1, 1, 0, 8);

    // 3: storage wait insertion mid-burst.
    if_a.devsel_n = 0; if_a.frame_n = 0; if_a.irdy_n = 0; if_a.storage_ready = 1;
    step(); chk_a("t3_e0", 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(); chk_a($sformatf("t3_e%0d", k), 0, 1, 1, k);
    end
    if_a.storage_ready = 0;
    step(); chk_a("t3_drop", 1, 1, 1, 4);
    step(); chk_a("t3_wait", 1, 1, 0, 4);
    if_a.storage_ready = 1;
    step(); chk_a("t3_back", 0, 1, 0, 4);
    step(); chk_a("t3_xfer", 0, 1, 1, 5);

    // 4: TRDY# held while initiator not ready; storage_ready ignored.
    if_a.irdy_n = 1;
    for (int k = 0; k < 4; k++) begin
      if_a.storage_ready = k[0];
      step(); chk_a($sformatf("t4_hold%0d", k), 0, 1, 0, 5);
    end
    if_a.irdy_n = 0; if_a.storage_ready = 1;
    step(); chk_a("t4_xfer", 0, 1, 1, 6);
    if_a.devsel_n = 1; if_a.irdy_n = 1; if_a.frame_n = 1;
    step(); chk_a("t4_release", 1, 1, 0, 6);

    // 5: normal completion on the third phase.
    if_a.devsel_n = 0; if_a.frame_n = 0; if_a.irdy_n = 0; if_a.storage_ready = 1;
    step(); chk_a("t5_e0", 0, 1, 0, 0);
    step(); chk_a("t5_e1", 0, 1, 1, 1);
    step(); chk_a("t5_e2", 0, 1, 1, 2);
    if_a.frame_n = 1;
    step(); chk_a("t5_last", 1, 1, 1, 3);
    if_a.devsel_n = 1; if_a.irdy_n = 1;
    step(); chk_a("t5_idle0", 1, 1, 0, 3);
    step(); chk_a("t5_idle1", 1, 1, 0, 3);
    if_a.devsel_n = 0; if_a.frame_n = 0;
    step(); chk_a("t5_reclaim", 0, 1, 0, 0);
    if_a.devsel_n = 1; if_a.frame_n = 1;
    step(); chk_a("t5_rel", 1, 1, 0, 0);

    // 6: reset mid-burst overrides everything, devsel_n ignored.
    if_a.devsel_n = 0; if_a.frame_n = 0; if_a.irdy_n = 0; if_a.storage_ready = 1;
    step(); chk_a("t6_e0", 0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step(); chk_a($sformatf("t6_e%0d", k), 0, 1, 1, k);
    end
    rst = 1'b1;
    step(); chk_a("t6_rst0", 1, 1, 0, 0);
    step(); chk_a("t6_rst1", 1, 1, 0, 0);
    rst = 1'b0; if_a.devsel_n = 1; if_a.irdy_n = 1; if_a.frame_n = 1;
    step(); chk_a("t6_after", 1, 1, 0, 0);
    if_a.devsel_n = 0;
    step(); chk_a("t6_claim", 0, 1, 0, 0);
    if_a.devsel_n = 1;
    step(); chk_a("t6_rel", 1, 1, 0, 0);

    // 2: two initial wait states.
    if_b.devsel_n = 0; if_b.frame_n = 0; if_b.irdy_n = 0; if_b.storage_ready = 1;
    step(); chk_b("t2_e0", 1, 1, 0, 0);
    step(); chk_b("t2_e1", 1, 1, 0, 0);
    step(); chk_b("t2_e2", 0, 1, 0, 0);
    step(); chk_b("t2_e3", 0, 1, 1, 1);
    if_b.frame_n = 1;
    step(); chk_b("t2_last", 1, 1, 1, 2);
    if_b.devsel_n = 1; if_b.irdy_n = 1;
    step(); chk_b("t2_idle", 1, 1, 0, 2);

    // Claim dropped during the wait period restarts the full wait.
    if_b.devsel_n = 0; if_b.frame_n = 0;
    step(); chk_b("t2a_e0", 1, 1, 0, 0);
    if_b.devsel_n = 1;
    step(); chk_b("t2a_abort", 1, 1, 0, 0);
    if_b.devsel_n = 0;
    step(); chk_b("t2a_r0", 1, 1, 0, 0);
    step(); chk_b("t2a_r1", 1, 1, 0, 0);
    step(); chk_b("t2a_r2", 0, 1, 0, 0);
    if_b.devsel_n = 1; if_b.frame_n = 1;
    step(); chk_b("t2a_rel", 1, 1, 0, 0);

    // MAX_BURST=1: disconnect after the very first transfer.
    if_c.devsel_n = 0; if_c.frame_n = 0; if_c.irdy_n = 0; if_c.storage_ready = 1;
    step(); chk_c("tc_e0", 0, 1, 0, 0);
    step(); chk_c("tc_e1", 1, 0, 1, 1);
    step(); chk_c("tc_hold", 1, 0, 0, 1);
    if_c.frame_n = 1; if_c.irdy_n = 1;
    step(); chk_c("tc_stop_rel", 1, 1, 0, 1);
    if_c.devsel_n = 1;
    step(); chk_c("tc_idle", 1, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
